// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg
//   Shared definitions for the MMIO bridge: FSM state encoding, the address
//   prefix that marks the external peripheral region, and a decode helper.
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } mmio_state_t;

    // Top two address bits equal to this value select the peripheral bus.
    localparam logic [1:0] EXT_REGION = 2'b11;

    function automatic logic is_ext_region(input logic [1:0] prefix);
        return prefix == EXT_REGION;
    endfunction

endpackage

// File: rtl/mmio_bridge_timer.sv
// mmio_bridge_timer
//   Wait-state counter that bounds a single peripheral access.
//   Ports:
//     clk, rst_n  clock / async active-low reset
//     clr         synchronous clear to zero (wins over en)
//     en          count one cycle
//     expired     count has reached TIMEOUT-1 (last permitted cycle)
module mmio_bridge_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge
//   Routes external data-memory accesses from the EX_DM stage onto NUM_CH
//   acknowledge-based peripheral channels, stalling the pipeline while an
//   access is in flight. Each access is bounded by a timeout; timeouts return
//   ERR_DATA and record a sticky bus error with the first failing address.
//   Ports:
//     cpu_addr/cpu_wdata/cpu_re/cpu_we   request from EX_DM
//     cpu_rdata/cpu_ext                  load data + external-select for DM_WB
//     cpu_stall                          hold all pipeline stages
//     ch_sel/ch_addr/ch_wdata/ch_re/ch_we  peripheral request (held until ack)
//     ch_ack/ch_rdata                    per-channel completion and read data
//     err_clr/bus_err/err_addr           sticky timeout status
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                NUM_CH   = 4,
    parameter int                CH_W     = 2,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    input  logic                       cpu_re,
    input  logic                       cpu_we,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_ext,
    output logic                       cpu_stall,
    output logic [NUM_CH-1:0]          ch_sel,
    output logic [ADDR_W-2-CH_W-1:0]   ch_addr,
    output logic [DATA_W-1:0]          ch_wdata,
    output logic                       ch_re,
    output logic                       ch_we,
    input  logic [NUM_CH-1:0]          ch_ack,
    input  logic [NUM_CH*DATA_W-1:0]   ch_rdata,
    input  logic                       err_clr,
    output logic                       bus_err,
    output logic [ADDR_W-1:0]          err_addr
);

    localparam int LA_W = ADDR_W - 2 - CH_W;

    mmio_state_t       state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CH_W-1:0]   lat_ch;
    logic              ext_req;
    logic [CH_W-1:0]   req_ch;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_rdata;
    logic              tmr_expired;

    assign ext_req   = (cpu_re || cpu_we) && is_ext_region(cpu_addr[ADDR_W-1 -: 2]);
    assign req_ch    = cpu_addr[ADDR_W-3 -: CH_W];

    // Only the latched channel may complete the access.
    assign sel_ack   = ch_ack[lat_ch];
    assign sel_rdata = ch_rdata[int'(lat_ch)*DATA_W +: DATA_W];

    // Mealy in IDLE so the pipeline freezes in the request cycle itself.
    // Gated by reset so an abandoned access releases the pipeline at once.
    assign cpu_stall = rst_n && ((state == ST_IDLE && ext_req) || state == ST_ACCESS);

    assign ch_addr  = lat_addr[LA_W-1:0];
    assign ch_wdata = lat_wdata;

    mmio_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_IDLE),
        .en      (state == ST_ACCESS),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_ch    <= '0;
            ch_sel    <= '0;
            ch_re     <= 1'b0;
            ch_we     <= 1'b0;
            cpu_ext   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_ext <= 1'b0;
                    if (ext_req) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_ch    <= req_ch;
                        ch_sel    <= NUM_CH'(1) << req_ch;
                        // re & we together is a write.
                        ch_we     <= cpu_we;
                        ch_re     <= !cpu_we;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (sel_ack) begin
                        cpu_rdata <= sel_rdata;
                        cpu_ext   <= 1'b1;
                        ch_sel    <= '0;
                        ch_re     <= 1'b0;
                        ch_we     <= 1'b0;
                        state     <= ST_DONE;
                    end else if (tmr_expired) begin
                        cpu_rdata <= ERR_DATA;
                        cpu_ext   <= 1'b1;
                        ch_sel    <= '0;
                        ch_re     <= 1'b0;
                        ch_we     <= 1'b0;
                        state     <= ST_ERR;
                    end
                end
                // Pipeline advances at the end of DONE/ERR, so the request
                // still on the inputs is not decoded again.
                ST_DONE, ST_ERR: begin
                    cpu_ext <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error: first error wins, but a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (state == ST_ERR && (!bus_err || err_clr)) begin
            bus_err  <= 1'b1;
            err_addr <= lat_addr;
        end else if (err_clr) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end
    end

endmodule
